uart_rx_axis_fifo: RTL
======================

Name: uart_rx_axis_fifo

Overview:
Downstream stage of the UART receiver. Accepts single-cycle rx_data/rx_valid byte pulses, which carry no backpressure. Buffers the bytes in a first-word-fall-through FIFO and presents them as an AXI-Stream master to the fabric. Reports overflow when the consumer cannot keep up with the line rate.

Parameters:
DATA_BITS, 8, width of each received word and of m_axis_tdata
DEPTH, 16, FIFO entries; must be a power of 2 and at least 2
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_data  in  DATA_BITS  byte from the UART receiver; valid only when rx_valid=1
rx_valid  in  1  one-cycle pulse; a new byte is present
m_axis_tdata  out  DATA_BITS  head-of-FIFO byte
m_axis_tvalid  out  1  FIFO non-empty
m_axis_tready  in  1  consumer ready
fill_level  out  ADDR_W+1  current entry count, 0..DEPTH
overflow  out  1  sticky; set when a byte is dropped
clear_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (rst=1, async):
  - wr_ptr, rd_ptr and count go to 0; m_axis_tvalid=0, fill_level=0, overflow=0.
  - Memory contents are don't-care; m_axis_tdata reset value is 0 (held by an output mux gate while empty).
- Push: rx_valid=1 and (count<DEPTH or pop this cycle).
  - mem[wr_ptr]<=rx_data; wr_ptr increments modulo DEPTH.
- Pop: m_axis_tvalid && m_axis_tready.
  - rd_ptr increments modulo DEPTH.
- Count rules:
  - push only: +1; pop only: -1; push and pop together: unchanged.
- Read side is FWFT:
  - m_axis_tdata = mem[rd_ptr] when count!=0, else 0.
  - m_axis_tvalid = (count!=0), driven from a registered count.
- Latency: a byte pushed in cycle N with the FIFO empty shows m_axis_tvalid=1 and that byte on tdata in cycle N+1.
- AXIS rules:
  - tdata and tvalid are stable while tvalid=1 and tready=0.
  - tvalid never depends combinationally on tready.
- Full (count==DEPTH) with rx_valid=1 and no pop in the same cycle:
  - The byte is dropped; pointers and count are unchanged.
  - overflow<=1 on the next edge.
- Full with rx_valid=1 and a pop in the same cycle: the push is accepted and count stays at DEPTH.
- Empty with m_axis_tready=1: no pop; rd_ptr is unchanged.
- Overflow flag:
  - clear_ovf=1 clears it.
  - A new drop in the same cycle as clear_ovf wins: overflow stays 1.
- Pointers wrap naturally at DEPTH. Full vs empty is resolved by count, not by pointer equality.
- rx_valid asserted on consecutive cycles (not possible from the receiver, but legal here) is accepted every cycle.
- There is no state machine beyond the pointer and count registers. All outputs except tdata are registered.

Optional Feature:
Macro UART_RX_OVF_CNT_EN.
- Defined:
  - Adds output ovf_count, 8 bits: a saturating count of dropped bytes that holds at 255.
  - Reset to 0; cleared by clear_ovf.
  - A drop coinciding with clear_ovf leaves ovf_count=1.
- Undefined: the port and its logic are absent; only the sticky overflow flag exists.

Decomposition:
- Shared package uart_axis_pkg holds:
  - DATA_BITS default (8) and FIFO DEPTH default (16), shared with the UART TX path.
  - The OVF_CNT_W=8 constant.
- One natural sub-module, uart_fifo_mem: a DEPTH x DATA_BITS register array with a synchronous write port and an asynchronous read port.
- Pointer and count control stays in uart_rx_axis_fifo.

Test Plan:
- Reset released, tready=1; push 0xA5 at cycle N.
  - Response: tvalid=1, tdata=0xA5 at N+1; one handshake; tvalid=0 at N+2; fill_level returns to 0.
- tready=0; push 16 bytes 0x00..0x0F.
  - Response: fill_level=16, overflow=0, tdata=0x00 held stable.
  - Then raise tready: bytes 0x00..0x0F drain in order, one per cycle.
- FIFO full with tready=0; push 0x77.
  - Response: overflow=1, fill_level=16.
  - On drain, 0x77 never appears; with UART_RX_OVF_CNT_EN, ovf_count=1.
- FIFO full with tready=1; push 0x55 in the same cycle as the pop.
  - Response: fill_level stays 16; 0x55 emerges 16th after the pop.
- Overflow set; drop and clear_ovf in the same cycle.
  - Response: overflow remains 1; clear_ovf alone the next cycle gives overflow=0.
- 5 bytes buffered, rst pulsed asynchronously mid-stream.
  - Response: tvalid=0 and fill_level=0 immediately; the next push 0x3C appears alone at the head.

Source files
------------

// File: rtl/uart_axis_pkg.sv
// Constants shared by the UART RX and TX stream paths.
package uart_axis_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int OVF_CNT_W       = 8;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset on the array.
module uart_fifo_mem #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_axis_fifo.sv
// UART RX byte pulses buffered in a FWFT FIFO and presented as an AXI-Stream master.
// Define UART_RX_OVF_CNT_EN to add the saturating ovf_count output.
module uart_rx_axis_fifo
  import uart_axis_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = UART_FIFO_DEPTH,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_valid,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [ADDR_W:0]      fill_level,
  output logic                 overflow,
  input  logic                 clear_ovf
`ifdef UART_RX_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [ADDR_W:0]      count;
  logic [ADDR_W:0]      count_next;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 drop;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop  = m_axis_tvalid && m_axis_tready;
  assign push = rx_valid && ((count != FULL) || pop);
  assign drop = rx_valid && !push;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (ADDR_W+1)'(1);
      2'b01:   count_next = count - (ADDR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count         <= count_next;
      m_axis_tvalid <= (count_next != '0);
    end
  end

  // A drop in the same cycle as clear_ovf keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

`ifdef UART_RX_OVF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ovf_count <= '0;
    else if (clear_ovf)             ovf_count <= OVF_CNT_W'(drop);
    else if (drop && ovf_count != '1) ovf_count <= ovf_count + OVF_CNT_W'(1);
  end
`endif

  uart_fifo_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (rx_data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign fill_level   = count;
  assign m_axis_tdata = m_axis_tvalid ? head : '0;

endmodule
